// File: rtl/video_sprite_motion_pkg.sv
// Shared types and offsets for the sprite motion controller.
// Holds the FSM state enum and the remote/local register offsets.
package video_sprite_motion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_X = 2'd1,
    WR_Y = 2'd2
  } state_e;

  localparam int unsigned REM_CTRL = 32'h0;
  localparam int unsigned REM_X    = 32'h4;
  localparam int unsigned REM_Y    = 32'h8;

  localparam int unsigned LOC_CTRL = 32'h0;
  localparam int unsigned LOC_XVEL = 32'h4;
  localparam int unsigned LOC_YVEL = 32'h8;

endpackage

// File: rtl/video_sprite_motion_axis.sv
// One-axis position/velocity step with edge handling.
// SPRITE_MOTION_BOUNCE_EN selects bounce; otherwise the position wraps.
module video_sprite_motion_axis (
  input  logic [15:0] pos,
  input  logic [15:0] vel,
  input  logic [15:0] max,
  output logic [15:0] nxt_pos,
  output logic [15:0] nxt_vel
);

  logic signed [16:0] nxt;
  logic signed [16:0] lim;

  always_comb begin
    nxt     = $signed({1'b0, pos}) + $signed({vel[15], vel});
    lim     = $signed({1'b0, max});
    nxt_pos = nxt[15:0];
    nxt_vel = vel;
    if (nxt < 0) begin
`ifdef SPRITE_MOTION_BOUNCE_EN
      nxt_pos = '0;
      nxt_vel = -vel;
`else
      nxt_pos = max;
`endif
    end else if (nxt > lim) begin
`ifdef SPRITE_MOTION_BOUNCE_EN
      nxt_pos = max;
      nxt_vel = -vel;
`else
      nxt_pos = '0;
`endif
    end
  end

endmodule

// File: rtl/video_sprite_motion_ctrl.sv
// Sprite motion controller: CPU passthrough plus per-frame x/y writes.
// Edge behaviour set by SPRITE_MOTION_BOUNCE_EN (bounce) or wrap by default.
module video_sprite_motion_ctrl
  import video_sprite_motion_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int SPRITE_HSIZE = 32,
  parameter int SPRITE_VSIZE = 32,
  parameter int X_ORIGIN     = 0,
  parameter int Y_ORIGIN     = 0,
  parameter int X_VEL        = 1,
  parameter int Y_VEL        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avs_write,
  input  logic [ADDR_W:0]   avs_address,
  input  logic [31:0]       avs_writedata,
  input  logic              frame_tick,
  output logic              avm_write,
  output logic [ADDR_W-1:0] avm_address,
  output logic [31:0]       avm_writedata
);

  localparam logic [ADDR_W-1:0] A_X    = ADDR_W'(REM_X);
  localparam logic [ADDR_W-1:0] A_Y    = ADDR_W'(REM_Y);
  localparam logic [ADDR_W-1:0] L_CTRL = ADDR_W'(LOC_CTRL);
  localparam logic [ADDR_W-1:0] L_XV   = ADDR_W'(LOC_XVEL);
  localparam logic [ADDR_W-1:0] L_YV   = ADDR_W'(LOC_YVEL);
  localparam logic [15:0] MAX_X = 16'(H_DISPLAY - SPRITE_HSIZE);
  localparam logic [15:0] MAX_Y = 16'(V_DISPLAY - SPRITE_VSIZE);

  state_e            state_q, state_d;
  logic [15:0]       pos_x_q, pos_x_d;
  logic [15:0]       pos_y_q, pos_y_d;
  logic [15:0]       x_vel_q, x_vel_d;
  logic [15:0]       y_vel_q, y_vel_d;
  logic              en_q, en_d;
  logic [15:0]       nx_pos, nx_vel;
  logic [15:0]       ny_pos, ny_vel;
  logic              pt_wr, loc_wr;
  logic [ADDR_W-1:0] off;

  assign off    = avs_address[ADDR_W-1:0];
  assign pt_wr  = avs_write & ~avs_address[ADDR_W];
  assign loc_wr = avs_write &  avs_address[ADDR_W];

  video_sprite_motion_axis u_axis_x (
    .pos     (pos_x_q),
    .vel     (x_vel_q),
    .max     (MAX_X),
    .nxt_pos (nx_pos),
    .nxt_vel (nx_vel)
  );

  video_sprite_motion_axis u_axis_y (
    .pos     (pos_y_q),
    .vel     (y_vel_q),
    .max     (MAX_Y),
    .nxt_pos (ny_pos),
    .nxt_vel (ny_vel)
  );

  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    x_vel_d       = x_vel_q;
    y_vel_d       = y_vel_q;
    en_d          = en_q;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;

    if (loc_wr) begin
      unique case (1'b1)
        (off == L_CTRL): en_d    = avs_writedata[0];
        (off == L_XV):   x_vel_d = avs_writedata[15:0];
        (off == L_YV):   y_vel_d = avs_writedata[15:0];
        default: ;
      endcase
    end

    // CPU owns the bus; a CPU write of the pending axis retires that step
    if (pt_wr) begin
      avm_write     = 1'b1;
      avm_address   = off;
      avm_writedata = avs_writedata;
      if (off == A_X) pos_x_d = avs_writedata[15:0];
      if (off == A_Y) pos_y_d = avs_writedata[15:0];
      if (state_q == WR_X && off == A_X) state_d = WR_Y;
      if (state_q == WR_Y && off == A_Y) state_d = IDLE;
    end else if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (frame_tick && en_q) begin
            pos_x_d = nx_pos;
            x_vel_d = nx_vel;
            pos_y_d = ny_pos;
            y_vel_d = ny_vel;
            state_d = WR_X;
          end
        end
        WR_X: begin
          avm_write     = 1'b1;
          avm_address   = A_X;
          avm_writedata = {16'b0, pos_x_q};
          state_d       = WR_Y;
        end
        WR_Y: begin
          avm_write     = 1'b1;
          avm_address   = A_Y;
          avm_writedata = {16'b0, pos_y_q};
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_x_q <= 16'(X_ORIGIN);
      pos_y_q <= 16'(Y_ORIGIN);
      x_vel_q <= 16'(X_VEL);
      y_vel_q <= 16'(Y_VEL);
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      x_vel_q <= x_vel_d;
      y_vel_q <= y_vel_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_video_sprite_motion_ctrl.sv
// Self-checking bench for video_sprite_motion_ctrl.
// Honours SPRITE_MOTION_BOUNCE_EN the same way the design does.
module tb_video_sprite_motion_ctrl;

  localparam int MAXX = 640 - 32;
  localparam int MAXY = 480 - 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        avs_write;
  logic [13:0] avs_address;
  logic [31:0] avs_writedata;
  logic        frame_tick;
  logic        avm_write;
  logic [12:0] avm_address;
  logic [31:0] avm_writedata;

  int n_checks = 0;
  int n_fail   = 0;

  int mx, my, mvx, mvy;
  bit men;

  video_sprite_motion_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .avs_write     (avs_write),
    .avs_address   (avs_address),
    .avs_writedata (avs_writedata),
    .frame_tick    (frame_tick),
    .avm_write     (avm_write),
    .avm_address   (avm_address),
    .avm_writedata (avm_writedata)
  );

  always #5 clk = ~clk;

  task automatic axis_step(inout int p, inout int v, input int lim);
    int n;
    n = p + v;
`ifdef SPRITE_MOTION_BOUNCE_EN
    if (n < 0) begin p = 0; v = -v; end
    else if (n > lim) begin p = lim; v = -v; end
    else p = n;
`else
    if (n < 0) p = lim;
    else if (n > lim) p = 0;
    else p = n;
`endif
  endtask

  task automatic model_tick();
    if (men) begin
      axis_step(mx, mvx, MAXX);
      axis_step(my, mvy, MAXY);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mvx = 1; mvy = 1; men = 0;
  endtask

  // Inputs change 1 time unit after posedge; outputs are read 1 unit later.
  task automatic drive(input logic t, input logic w,
                       input logic [13:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    frame_tick    = t;
    avs_write     = w;
    avs_address   = a;
    avs_writedata = d;
    #1;
  endtask

  task automatic set_pos(input int x, input int y);
    drive(1'b0, 1'b1, {1'b0, 13'h4}, 32'(x));
    drive(1'b0, 1'b1, {1'b0, 13'h8}, 32'(y));
    mx = x; my = y;
  endtask

  task automatic set_vel(input int vx, input int vy);
    drive(1'b0, 1'b1, {1'b1, 13'h4}, 32'(vx));
    drive(1'b0, 1'b1, {1'b1, 13'h8}, 32'(vy));
    mvx = vx; mvy = vy;
  endtask

  task automatic set_en(input bit e);
    drive(1'b0, 1'b1, {1'b1, 13'h0}, {31'b0, e});
    men = e;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 0; avs_write = 0;
    avs_address = '0; avs_writedata = '0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      n_checks++;
      if (avm_write !== 1'b0 || avm_address !== 13'h0 || avm_writedata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_out cyc%0d: got w=%b a=%h d=%h want 0/0/0",
                 k, avm_write, avm_address, avm_writedata);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 1'b0, '0, '0);
      n_checks++;
      if (avm_write !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_en cyc%0d: got w=%b want 0", k, avm_write);
      end
    end
    set_en(1'b1);
    model_tick();
    for (int k = 0; k < 4; k++) begin
      logic ew; logic [12:0] ea; logic [31:0] ed;
      drive(k == 0, 1'b0, '0, '0);
      ew = (k == 1 || k == 2);
      ea = (k == 1) ? 13'h4 : (k == 2) ? 13'h8 : 13'h0;
      ed = (k == 1) ? 32'd1 : (k == 2) ? 32'd1 : 32'd0;
      n_checks++;
      if (avm_write !== ew || avm_address !== ea || avm_writedata !== ed) begin
        n_fail++;
        $display("FAIL reset_origin cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                 k, avm_write, avm_address, avm_writedata, ew, ea, ed);
      end
    end
  endtask

  task automatic test_basic_move();
    set_en(1'b1);
    set_pos(100, 50);
    set_vel(3, -2);
    model_tick();
    for (int k = 0; k < 4; k++) begin
      logic ew; logic [12:0] ea; logic [31:0] ed;
      drive(k == 0, 1'b0, '0, '0);
      ew = (k == 1 || k == 2);
      ea = (k == 1) ? 13'h4 : (k == 2) ? 13'h8 : 13'h0;
      ed = (k == 1) ? 32'd103 : (k == 2) ? 32'd48 : 32'd0;
      n_checks++;
      if (avm_write !== ew || avm_address !== ea || avm_writedata !== ed) begin
        n_fail++;
        $display("FAIL basic_move cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                 k, avm_write, avm_address, avm_writedata, ew, ea, ed);
      end
    end
  endtask

  task automatic test_edges();
    int ex[2];
    int ey[2];
`ifdef SPRITE_MOTION_BOUNCE_EN
    set_pos(606, 2);
    ex[0] = 608; ey[0] = 0;
    ex[1] = 603; ey[1] = 3;
`else
    set_pos(607, 1);
    ex[0] = 0; ey[0] = 448;
    ex[1] = 5; ey[1] = 445;
`endif
    set_vel(5, -3);
    for (int t = 0; t < 2; t++) begin
      model_tick();
      for (int k = 0; k < 4; k++) begin
        logic ew; logic [12:0] ea; logic [31:0] ed;
        drive(k == 0, 1'b0, '0, '0);
        ew = (k == 1 || k == 2);
        ea = (k == 1) ? 13'h4 : (k == 2) ? 13'h8 : 13'h0;
        ed = (k == 1) ? 32'(ex[t]) : (k == 2) ? 32'(ey[t]) : 32'd0;
        n_checks++;
        if (avm_write !== ew || avm_address !== ea || avm_writedata !== ed) begin
          n_fail++;
          $display("FAIL edge t%0d cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                   t, k, avm_write, avm_address, avm_writedata, ew, ea, ed);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic        ew[5];
    logic [12:0] ea[5];
    logic [31:0] ed[5];
    set_pos(300, 200);
    set_vel(-7, 9);
    model_tick();
    ew = '{0, 1, 1, 1, 0};
    ea = '{13'h0, 13'h10, 13'h4, 13'h8, 13'h0};
    ed = '{32'h0, 32'hABCD1234, 32'(mx), 32'(my), 32'h0};
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive(1'b0, 1'b1, {1'b0, 13'h10}, 32'hABCD1234);
      else        drive(k == 0, 1'b0, '0, '0);
      n_checks++;
      if (avm_write !== ew[k] || avm_address !== ea[k] || avm_writedata !== ed[k]) begin
        n_fail++;
        $display("FAIL contention cyc%0d: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                 k, avm_write, avm_address, avm_writedata, ew[k], ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_override();
    logic        ew[4];
    logic [12:0] ea[4];
    logic [31:0] ed[4];
    set_pos(10, 20);
    set_vel(1, 1);
    model_tick();
    ew = '{0, 1, 1, 0};
    ea = '{13'h0, 13'h4, 13'h8, 13'h0};
    ed = '{32'h0, 32'd200, 32'(my), 32'h0};
    for (int k = 0; k < 4; k++) begin
      if (k == 1) drive(1'b0, 1'b1, {1'b0, 13'h4}, 32'd200);
      else        drive(k == 0, 1'b0, '0, '0);
      n_checks++;
      if (avm_write !== ew[k] || avm_address !== ea[k] || avm_writedata !== ed[k]) begin
        n_fail++;
        $display("FAIL override cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                 k, avm_write, avm_address, avm_writedata, ew[k], ea[k], ed[k]);
      end
    end
    mx = 200;
    set_vel(3, mvy);
    model_tick();
    for (int k = 0; k < 4; k++) begin
      logic xw; logic [12:0] xa; logic [31:0] xd;
      drive(k == 0, 1'b0, '0, '0);
      xw = (k == 1 || k == 2);
      xa = (k == 1) ? 13'h4 : (k == 2) ? 13'h8 : 13'h0;
      xd = (k == 1) ? 32'd203 : (k == 2) ? 32'(my) : 32'd0;
      n_checks++;
      if (avm_write !== xw || avm_address !== xa || avm_writedata !== xd) begin
        n_fail++;
        $display("FAIL override_next cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                 k, avm_write, avm_address, avm_writedata, xw, xa, xd);
      end
    end
  endtask

  task automatic test_drop_and_disable();
    logic        ew[5];
    logic [12:0] ea[5];
    logic [31:0] ed[5];
    set_pos(40, 40);
    set_vel(4, 4);
    model_tick();
    ew = '{0, 1, 1, 0, 0};
    ea = '{13'h0, 13'h4, 13'h8, 13'h0, 13'h0};
    ed = '{32'h0, 32'(mx), 32'(my), 32'h0, 32'h0};
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive(1'b1, 1'b1, {1'b1, 13'h0}, 32'h0);
      else        drive(k < 4, 1'b0, '0, '0);
      n_checks++;
      if (avm_write !== ew[k] || avm_address !== ea[k] || avm_writedata !== ed[k]) begin
        n_fail++;
        $display("FAIL drop_disable cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                 k, avm_write, avm_address, avm_writedata, ew[k], ea[k], ed[k]);
      end
    end
    men = 0;
  endtask

  task automatic test_mid_reset();
    set_en(1'b1);
    set_pos(50, 60);
    set_vel(2, 2);
    drive(1'b1, 1'b0, '0, '0);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (avm_write !== 1'b0 || avm_address !== 13'h0 || avm_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_wrx: got w=%b a=%h d=%h want 0/0/0",
               avm_write, avm_address, avm_writedata);
    end
    @(posedge clk); #2;
    n_checks++;
    if (avm_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_hold: got w=%b want 0", avm_write);
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 1'b0, '0, '0);
      n_checks++;
      if (avm_write !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_tick_ignored cyc%0d: got w=%b want 0", k, avm_write);
      end
    end
    set_en(1'b1);
    model_tick();
    for (int k = 0; k < 4; k++) begin
      logic ew; logic [12:0] ea; logic [31:0] ed;
      drive(k == 0, 1'b0, '0, '0);
      ew = (k == 1 || k == 2);
      ea = (k == 1) ? 13'h4 : (k == 2) ? 13'h8 : 13'h0;
      ed = (k == 1) ? 32'(mx) : (k == 2) ? 32'(my) : 32'd0;
      n_checks++;
      if (avm_write !== ew || avm_address !== ea || avm_writedata !== ed) begin
        n_fail++;
        $display("FAIL midrst_origin cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                 k, avm_write, avm_address, avm_writedata, ew, ea, ed);
      end
    end
  endtask

  task automatic test_random();
    set_en(1'b1);
    for (int it = 0; it < 20; it++) begin
      int nt;
      set_pos(int'($urandom_range(0, MAXX)), int'($urandom_range(0, MAXY)));
      set_vel(int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40);
      nt = int'($urandom_range(1, 3));
      for (int t = 0; t < nt; t++) begin
        model_tick();
        for (int k = 0; k < 4; k++) begin
          logic ew; logic [12:0] ea; logic [31:0] ed;
          drive(k == 0, 1'b0, '0, '0);
          ew = (k == 1 || k == 2);
          ea = (k == 1) ? 13'h4 : (k == 2) ? 13'h8 : 13'h0;
          ed = (k == 1) ? 32'(mx) : (k == 2) ? 32'(my) : 32'd0;
          n_checks++;
          if (avm_write !== ew || avm_address !== ea || avm_writedata !== ed) begin
            n_fail++;
            $display("FAIL random it%0d t%0d cyc%0d: got w=%b a=%h d=%0d want w=%b a=%h d=%0d",
                     it, t, k, avm_write, avm_address, avm_writedata, ew, ea, ed);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_edges();
    test_contention();
    test_override();
    test_drop_and_disable();
    test_mid_reset();
    test_random();
    drive(1'b0, 1'b0, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_sprite_motion_ctrl.md
VIDEO_SPRITE_MOTION_CTRL -- requirements
Module: video_sprite_motion_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W=13, addr width toward the sprite core; H_DISPLAY=640, visible width; V_DISPLAY=480, visible height; SPRITE_HSIZE=32, sprite width; SPRITE_VSIZE=32, sprite height; X_ORIGIN=0, reset x; Y_ORIGIN=0, reset y; X_VEL=1, reset signed x step per frame; Y_VEL=1, reset signed y step per frame.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 avs_write  input  1  CPU write strobe.
REQ-005 avs_address  input  ADDR_W+1  CPU byte address; bit ADDR_W=1 selects local registers, else passthrough.
REQ-006 avs_writedata  input  32  CPU write data.
REQ-007 frame_tick  input  1  one-cycle start-of-frame pulse.
REQ-008 avm_write  output  1  write strobe to the sprite animation core; no waitrequest.
REQ-009 avm_address  output  ADDR_W  address to the sprite core.
REQ-010 avm_writedata  output  32  data to the sprite core.

Function
REQ-011 Local registers (bit ADDR_W=1, low bits): 0x0 ctrl bit0 motion_en (reset 0); 0x4 x_vel, signed 16 bits [15:0] (reset X_VEL); 0x8 y_vel, signed 16 bits [15:0] (reset Y_VEL); other offsets are ignored.
REQ-012 A CPU write with bit ADDR_W=0 SHALL be forwarded combinationally the same cycle: avm_write=1, avm_address=avs_address[ADDR_W-1:0], avm_writedata=avs_writedata.
REQ-013 A forwarded write to offset 0x4 or 0x8 SHALL also load internal pos_x or pos_y from writedata[15:0].
REQ-014 FSM states SHALL be IDLE, WR_X and WR_Y; reset state is IDLE.
REQ-015 IDLE: on frame_tick=1 with motion_en=1, compute the next position and velocity, register them, and go to WR_X; otherwise stay in IDLE.
REQ-016 WR_X: with no CPU passthrough write, drive avm address 0x4 with data {16'b0,pos_x} and go to WR_Y.
REQ-017 WR_Y: with no CPU passthrough write, drive avm address 0x8 with data {16'b0,pos_y} and go to IDLE.
REQ-018 Arbitration: a CPU passthrough write SHALL always win the bus; the FSM SHALL hold its state that cycle and issue no write.
REQ-019 A CPU passthrough write to 0x4 while in WR_X SHALL make the FSM skip its x write and go to WR_Y; a CPU write to 0x8 in WR_Y SHALL make it skip to IDLE.
REQ-020 A frame_tick in WR_X or WR_Y SHALL be dropped with no queuing.
REQ-021 Latency without contention: frame_tick in cycle N gives the x write in N+1, the y write in N+2, and IDLE in N+3.
REQ-022 Arithmetic per axis: nxt = pos + vel, computed as signed 17-bit; max_x = H_DISPLAY-SPRITE_HSIZE; max_y = V_DISPLAY-SPRITE_VSIZE.
REQ-023 Edge handling depends on the macro (see Configuration); a position inside [0,max] SHALL be used unchanged.
REQ-024 Clearing motion_en mid-sequence SHALL NOT abort the sequence in progress; it only blocks new sequences.

Reset
REQ-025 On rst: FSM=IDLE, pos_x=X_ORIGIN, pos_y=Y_ORIGIN, x_vel=X_VEL, y_vel=Y_VEL, motion_en=0.
REQ-026 During and after rst, while no CPU passthrough write is present: avm_write=0, avm_address=0, avm_writedata=0.
REQ-027 rst asserted mid-sequence SHALL abandon any pending position write.

Configuration
REQ-028 With SPRITE_MOTION_BOUNCE_EN defined: nxt<0 gives pos=0 and vel=-vel; nxt>max gives pos=max and vel=-vel.
REQ-029 Without SPRITE_MOTION_BOUNCE_EN: nxt<0 gives pos=max; nxt>max gives pos=0; vel is unchanged.

Structure
REQ-030 A shared package video_sprite_motion_pkg SHALL hold the FSM state enum, the remote offsets (CTRL=0x0, X=0x4, Y=0x8) and the local register offsets.
REQ-031 Per-axis update SHALL live in sub-module video_sprite_motion_axis (inputs pos, vel, max; outputs nxt_pos, nxt_vel), instantiated twice.

Verification
REQ-032 Basic move: motion_en=1, pos=(100,50), vel=(3,-2), frame_tick -> avm writes (0x4,103) in N+1 and (0x8,48) in N+2.
REQ-033 Bounce (macro defined): pos_x=606, x_vel=5 (max_x 608), tick -> write x=608, x_vel becomes -5; next tick -> x=603.
REQ-034 Wrap (macro undefined): pos_y=1, y_vel=-3, tick -> write y=448 (max_y), y_vel stays -3.
REQ-035 Contention: CPU passthrough write to 0x10 in N+1 -> CPU write forwarded in N+1, x write in N+2, y write in N+3.
REQ-036 Override: CPU write 0x4=200 in WR_X -> no FSM x write, pos_x=200; next tick with x_vel=3 -> x write of 203.
REQ-037 Reset mid-sequence: rst during WR_X -> no avm_write, pos=(X_ORIGIN,Y_ORIGIN), motion_en=0, later frame_tick ignored.
